reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Shares the single register-file write port between the pipeline write-back stage and an auxiliary long-latency result source, such as the multiply/divide unit or uncached load returns. Write-back has priority. Auxiliary results wait in a small FIFO and drain into idle write-port cycles. A starvation counter briefly stalls write-back so that queued results always retire. The block sits between the write-back stage and the register file, and exports a pending-write mask that decode uses for hazard detection.

## Interface
- DEPTH, 4, auxiliary FIFO entries (power of two, ≥2)
- MAX_WAIT, 8, cycles the FIFO head may wait before write-back is forced to stall (≥1)

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  write-back stage requests a register write
- wb_reg  in  5  write-back destination register
- wb_data  in  32  write-back data
- wb_stall  out  1  write-back must hold its request this cycle
- aux_valid  in  1  auxiliary source offers a result
- aux_reg  in  5  auxiliary destination register
- aux_data  in  32  auxiliary data
- aux_ready  out  1  auxiliary result is accepted this cycle when high
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- busy  out  1  the FIFO holds at least one entry
- pending_mask  out  32  bit r is set when a live queued entry targets register r

## Operation
- **FIFO state:** circular buffer with head and tail pointers, a count (0..DEPTH), and a live bit per entry.
- **Acceptance:** aux_ready = (count < DEPTH).
  - An aux handshake is aux_valid && aux_ready.
  - An aux write to register 0 is accepted and discarded.
- **Port priority, evaluated each cycle:**
  1. Force: the head is live and wait_cnt == MAX_WAIT.
     - wb_stall=1, the port drives the head entry, and the head is popped.
     - wb inputs are ignored this cycle.
  2. Write-back: wb_valid and wb_reg≠0.
     - The port drives the wb inputs.
     - Every live FIFO entry with reg == wb_reg is killed (live bit cleared). Queued results are older and must lose.
     - A same-cycle incoming aux with aux_reg == wb_reg is accepted and dropped.
  3. Drain: the head is live. The port drives the head entry and the head is popped.
  4. Otherwise rf_we=0.
- **Dead heads:** a killed (non-live) head is popped silently in any cycle without using the port.
- **Simultaneous events:** a pop and a push in the same cycle keep count unchanged.
- **Starvation counter (wait_cnt):**
  - Increments while a live head is not popped.
  - Clears on any pop and whenever the FIFO is empty.
  - Saturates at MAX_WAIT.
- **Write-back to register 0:** treated as no request. The drain rule may use the port.
- **Outputs:** pending_mask and busy derive from registered FIFO state. Register 0's bit is never set.
- **Reset:** FIFO empty, all live bits 0, wait_cnt 0.
  - Outputs after reset: rf_we=0, wb_stall=0, aux_ready=1, busy=0, pending_mask=0.
  - Reset mid-operation discards all queued entries.

## Timing
- rf_we, rf_waddr, rf_wdata and wb_stall are combinational from the inputs and the current FIFO state. The register file commits on the next edge.
- Write-back latency is 0 cycles. It is delayed exactly one cycle per forced drain.
- Forced drains are never back-to-back for one entry. A new head starts at wait_cnt=0, so at most one stall occurs per MAX_WAIT+1 cycles of continuous write-back traffic.
- Auxiliary latency (no bypass) is 1 cycle minimum: enqueue at edge N, write during cycle N+1.
- pending_mask updates one edge after push, pop or kill.

## Configuration
- REG_WRITE_ARBITER_BYPASS_EN
  - When defined: if the FIFO is empty, write-back issues no write, and no force is pending, a handshaken aux result (aux_reg≠0) drives the port in the same cycle and is not enqueued. Auxiliary latency is 0.
  - When undefined: every aux result passes through the FIFO.

## Test plan
- **Reset:** assert reset mid-drain with count=3 -> all outputs at reset values immediately; after release, aux_ready=1 and pending_mask=0.
- **Idle drain:** aux r5=0x1234 with wb idle -> rf_we=1, waddr=5, wdata=0x1234 the next cycle (same cycle with bypass); pending_mask bit5 is set for one cycle without bypass.
- **WAW kill:** queue aux r7=0xAAAA while wb writes r7=0xBBBB continuously -> entry killed, r7 written only with 0xBBBB, pending_mask bit7 clears, wb_stall never asserts.
- **Starvation:** MAX_WAIT=8, queue aux r3=0x55, wb writes r9 every cycle -> wb_stall=1 exactly on the 9th cycle after enqueue, rf_waddr=3 that cycle, wb r9 retires the cycle after.
- **Full:** DEPTH=4, wb busy on r1, push 4 aux results -> aux_ready=0 on the 5th offer; the first forced pop restores aux_ready=1.
- **Register 0:** aux r0 and wb r0 simultaneously with r2 queued -> r2 drains this cycle and no write to register 0 occurs.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: write-back first, aux results queue and drain into idle cycles, forced drain after MAX_WAIT.
// Port outputs are combinational (0-cycle wb, 1-cycle aux); aux_ready drops when full. Optional REG_WRITE_ARBITER_BYPASS_EN.
module reg_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        aux_valid,
    input  logic [4:0]  aux_reg,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic [31:0] pending_mask
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [WW-1:0] MAX_C   = WW'(MAX_WAIT);

    logic [4:0]       q_reg  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] live, live_next, kill;
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic [WW-1:0]    wait_cnt;

    logic head_live, head_dead, force_drain, wb_req, aux_hs;
    logic pop, push, kill_en, bypass;

    always_comb begin
        head_live   = (count != '0) && live[head];
        head_dead   = (count != '0) && !live[head];
        force_drain = head_live && (wait_cnt == MAX_C);
        wb_req      = wb_valid && (wb_reg != 5'd0);
        aux_ready   = (count < DEPTH_C);
        aux_hs      = aux_valid && aux_ready;

        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        wb_stall = 1'b0;
        pop      = 1'b0;
        kill_en  = 1'b0;
        bypass   = 1'b0;

        if (force_drain) begin
            rf_we    = 1'b1;
            rf_waddr = q_reg[head];
            rf_wdata = q_data[head];
            wb_stall = 1'b1;
            pop      = 1'b1;
        end else if (wb_req) begin
            rf_we    = 1'b1;
            rf_waddr = wb_reg;
            rf_wdata = wb_data;
            kill_en  = 1'b1;
            pop      = head_dead;
        end else if (head_live) begin
            rf_we    = 1'b1;
            rf_waddr = q_reg[head];
            rf_wdata = q_data[head];
            pop      = 1'b1;
        end else begin
            pop = head_dead;
`ifdef REG_WRITE_ARBITER_BYPASS_EN
            if ((count == '0) && aux_hs && (aux_reg != 5'd0)) begin
                rf_we    = 1'b1;
                rf_waddr = aux_reg;
                rf_wdata = aux_data;
                bypass   = 1'b1;
            end
`endif
        end

        // An aux result racing a younger write-back to the same register is stale on arrival.
        push = aux_hs && (aux_reg != 5'd0) && !bypass && !(kill_en && (aux_reg == wb_reg));
    end

    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = kill_en && live[i] && (q_reg[i] == wb_reg);
        end
        live_next = live & ~kill;
        if (pop) live_next[head] = 1'b0;
        if (push) live_next[tail] = 1'b1;
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) pending_mask[q_reg[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
        busy = (count != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            live     <= '0;
            wait_cnt <= '0;
        end else begin
            live <= live_next;
            if (pop) head <= head + 1'b1;
            if (push) tail <= tail + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop || (count == '0)) wait_cnt <= '0;
            else if (head_live && (wait_cnt != MAX_C)) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[tail]  <= aux_reg;
            q_data[tail] <= aux_data;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; register-file writes are scoreboarded by cycle, address and data.
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, aux_valid;
    logic [4:0]  wb_reg, aux_reg;
    logic [31:0] wb_data, aux_data;
    logic        wb_stall, aux_ready, rf_we, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pending_mask;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          c;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_has;

    reg_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
        .aux_valid(aux_valid), .aux_reg(aux_reg), .aux_data(aux_data), .aux_ready(aux_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every write must match the next expected write in cycle, address and data; due-but-absent writes fail too.
    always @(negedge clk) begin
        mon_has = (exp_q.size() != 0) && (exp_q[0].c == cyc);
        if (mon_has) mon_e = exp_q.pop_front();
        if (rf_we !== 1'b0 || mon_has) begin
            tests++;
            assert ((rf_we ? {1'b1, rf_waddr, rf_wdata} : 38'd0) ===
                    (mon_has ? {1'b1, mon_e.r, mon_e.d} : 38'd0))
            else begin
                fails++;
                $error("FAIL rf_write cyc=%0d: got we=%b r%0d=%h want we=%b r%0d=%h",
                       cyc, rf_we, rf_waddr, rf_wdata, mon_has, mon_e.r, mon_e.d);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_in();
        wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        aux_valid = 1'b0; aux_reg = 5'd0; aux_data = 32'd0;
    endtask

    task automatic expect_wr(input int off, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.c = cyc + off; e.r = r; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, "_wb_stall"}, {31'd0, wb_stall}, 32'd0);
        chk({tag, "_aux_ready"}, {31'd0, aux_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pending"}, pending_mask, 32'd0);
    endtask

    initial begin
        logic [4:0]  r;
        logic [31:0] d;
        reset = 1'b1;
        idle_in();
        mid();
        chk_reset_outs("por");
        tick(); tick();
        reset = 1'b0;

        // Idle drain
        aux_valid = 1'b1; aux_reg = 5'd5; aux_data = 32'h1234;
`ifdef REG_WRITE_ARBITER_BYPASS_EN
        expect_wr(0, 5'd5, 32'h1234);
`else
        expect_wr(1, 5'd5, 32'h1234);
`endif
        mid();
        chk("idle_aux_ready", {31'd0, aux_ready}, 32'd1);
        tick(); idle_in();
        mid();
`ifdef REG_WRITE_ARBITER_BYPASS_EN
        chk("idle_pending", pending_mask, 32'd0);
`else
        chk("idle_pending", pending_mask, 32'h20);
`endif
        tick(); mid();
        chk("idle_pending_clr", pending_mask, 32'd0);
        chk("idle_busy_clr", {31'd0, busy}, 32'd0);

        // WAW kill
        tick();
        wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h9;
        aux_valid = 1'b1; aux_reg = 5'd7; aux_data = 32'hAAAA;
        expect_wr(0, 5'd9, 32'h9);
        mid(); chk("waw_stall0", {31'd0, wb_stall}, 32'd0);
        tick();
        aux_valid = 1'b0; wb_reg = 5'd7; wb_data = 32'hBBBB;
        expect_wr(0, 5'd7, 32'hBBBB);
        mid();
        chk("waw_pending_set", pending_mask, 32'h80);
        chk("waw_stall1", {31'd0, wb_stall}, 32'd0);
        tick();
        expect_wr(0, 5'd7, 32'hBBBB);
        mid();
        chk("waw_pending_clr", pending_mask, 32'd0);
        chk("waw_stall2", {31'd0, wb_stall}, 32'd0);
        tick(); idle_in();
        mid(); chk("waw_busy_clr", {31'd0, busy}, 32'd0);

        // Starvation: forced drain on the 9th cycle after enqueue
        for (int k = 0; k <= 10; k++) begin
            tick();
            wb_valid = 1'b1; wb_reg = 5'd9;
            wb_data = 32'h900 + ((k > 9) ? 32'd9 : 32'(k));
            aux_valid = (k == 0); aux_reg = 5'd3; aux_data = 32'h55;
            if (k == 9) expect_wr(0, 5'd3, 32'h55);
            else expect_wr(0, 5'd9, wb_data);
            mid();
            chk($sformatf("starve_stall_k%0d", k), {31'd0, wb_stall}, {31'd0, (k == 9)});
        end
        tick(); idle_in();
        mid(); chk("starve_busy_clr", {31'd0, busy}, 32'd0);

        // Full FIFO
        for (int k = 0; k <= 14; k++) begin
            tick();
            wb_valid = (k <= 10); wb_reg = 5'd1; wb_data = 32'h111;
            r = 5'd10 + ((k < 4) ? 5'(k) : 5'd4);
            d = 32'hA0 + ((k < 4) ? 32'(k) : 32'd4);
            aux_valid = (k <= 10); aux_reg = r; aux_data = d;
            if (k <= 8 || k == 10) expect_wr(0, 5'd1, 32'h111);
            else if (k == 9) expect_wr(0, 5'd10, 32'hA0);
            else expect_wr(0, 5'd11 + 5'(k - 11), 32'hA1 + 32'(k - 11));
            mid();
            if (k <= 10)
                chk($sformatf("full_aux_ready_k%0d", k), {31'd0, aux_ready}, {31'd0, (k < 4 || k == 10)});
            chk($sformatf("full_stall_k%0d", k), {31'd0, wb_stall}, {31'd0, (k == 9)});
        end
        tick(); idle_in();
        mid(); chk("full_busy_clr", {31'd0, busy}, 32'd0);

        // Register 0 on both sources while r2 is queued
        tick();
        wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
        aux_valid = 1'b1; aux_reg = 5'd2; aux_data = 32'h22;
        expect_wr(0, 5'd9, 32'h99);
        tick();
        wb_reg = 5'd0; wb_data = 32'hBEEF;
        aux_reg = 5'd0; aux_data = 32'hDEAD;
        expect_wr(0, 5'd2, 32'h22);
        mid();
        chk("r0_aux_ready", {31'd0, aux_ready}, 32'd1);
        chk("r0_stall", {31'd0, wb_stall}, 32'd0);
        tick(); idle_in();
        mid();
        chk("r0_busy", {31'd0, busy}, 32'd0);
        chk("r0_pending", pending_mask, 32'd0);

        // Reset mid-drain with three entries queued
        for (int k = 0; k < 3; k++) begin
            tick();
            wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h1;
            aux_valid = 1'b1; aux_reg = 5'd4 + 5'(k); aux_data = 32'h40 + 32'(k);
            expect_wr(0, 5'd1, 32'h1);
        end
        tick(); idle_in();
        expect_wr(0, 5'd4, 32'h40);
        mid();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        chk("rst_pre_pending", pending_mask, 32'h70);
        #1 reset = 1'b1;
        #1 chk_reset_outs("rst_async");
        tick(); tick();
        reset = 1'b0;
        mid();
        chk("rst_post_aux_ready", {31'd0, aux_ready}, 32'd1);
        chk("rst_post_pending", pending_mask, 32'd0);
        chk("rst_post_busy", {31'd0, busy}, 32'd0);

        tick(); mid();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
